// File: rtl/conv_feed_dispatcher.sv
// Header-decoding feeder: routes DDR stream packets into per-unit config ports and weight/ftm buffers.
// Optional CONV_FEED_BCAST_EN: unit index 63 addresses every unit at once.
module conv_feed_dispatcher #(
  parameter int N_CONV_UNIT     = 8,
  parameter int DATA_WIDTH      = 64,
  parameter int UNIT_BURSTS_WEI = 32,
  parameter int UNIT_BURSTS_FTM = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  di,
  output logic [N_CONV_UNIT-1:0] wb_we,
  output logic [N_CONV_UNIT-1:0] fb_we,
  output logic [N_CONV_UNIT-1:0] wb_clr,
  output logic [N_CONV_UNIT-1:0] fb_clr,
  input  logic [N_CONV_UNIT-1:0] wb_full,
  input  logic [N_CONV_UNIT-1:0] fb_full,
  output logic [N_CONV_UNIT-1:0] cfg_valid,
  output logic [63:0]            cfg_data,
  input  logic [N_CONV_UNIT-1:0] cfg_ready,
  output logic                   err
);
  localparam int BW = $clog2(UNIT_BURSTS_FTM) + 1;
  localparam logic [1:0] T_CFG = 2'b00, T_WEI = 2'b01, T_FTM = 2'b10, T_CLR = 2'b11;
  localparam logic [N_CONV_UNIT-1:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, CFGW, CFGH, GAP, CHK, BURST, DRAIN} state_t;
  state_t state, state_nxt;

  logic [1:0]             h_typ;
  logic [5:0]             h_unit;
  logic [15:0]            h_len;
  logic                   h_ok;
  logic [N_CONV_UNIT-1:0] h_mask;

  assign h_typ  = s_data[63:62];
  assign h_unit = s_data[61:56];
  assign h_len  = s_data[55:40];

`ifdef CONV_FEED_BCAST_EN
  assign h_ok   = (h_unit < 6'(N_CONV_UNIT)) || (h_unit == 6'd63);
  assign h_mask = (h_unit == 6'd63) ? '1 : (ONE << h_unit);
`else
  assign h_ok   = h_unit < 6'(N_CONV_UNIT);
  assign h_mask = ONE << h_unit;
`endif

  logic [N_CONV_UNIT-1:0] mask;
  logic                   typ_ftm;
  logic [15:0]            rem;
  logic [BW-1:0]          bcnt;
  logic [15:0]            ub, blen;
  logic [N_CONV_UNIT-1:0] full_sel;
  logic                   err_set;

  assign ub       = typ_ftm ? 16'(UNIT_BURSTS_FTM) : 16'(UNIT_BURSTS_WEI);
  assign blen     = (rem > ub) ? ub : rem;
  assign full_sel = typ_ftm ? fb_full : wb_full;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (!h_ok) begin
            err_set   = 1'b1;
            state_nxt = s_last ? IDLE : DRAIN;
          end else begin
            case (h_typ)
              T_CFG: if (s_last) err_set = 1'b1; else state_nxt = CFGW;
              T_WEI, T_FTM:
                if (h_len != 16'd0) begin
                  if (s_last) err_set = 1'b1; else state_nxt = GAP;
                end
              default: ;
            endcase
          end
        end
      end
      CFGW: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) state_nxt = CFGH;
          else begin err_set = 1'b1; state_nxt = DRAIN; end
        end
      end
      // leave once every outstanding bit completes its handshake this cycle
      CFGH:  if ((cfg_valid & ~cfg_ready) == '0) state_nxt = IDLE;
      GAP:   state_nxt = CHK;
      CHK:   if ((full_sel & mask) == '0) state_nxt = BURST;
      BURST: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            if (rem != 16'd1) err_set = 1'b1;
            state_nxt = IDLE;
          end else if (rem == 16'd1) begin
            err_set   = 1'b1;
            state_nxt = DRAIN;
          end else if (bcnt == BW'(1)) begin
            state_nxt = GAP;
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rstn) s_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      di        <= '0;
      wb_we     <= '0;
      fb_we     <= '0;
      wb_clr    <= '0;
      fb_clr    <= '0;
      cfg_valid <= '0;
      cfg_data  <= '0;
      err       <= 1'b0;
      mask      <= '0;
      typ_ftm   <= 1'b0;
      rem       <= '0;
      bcnt      <= '0;
    end else begin
      state  <= state_nxt;
      wb_we  <= '0;
      fb_we  <= '0;
      wb_clr <= '0;
      fb_clr <= '0;
      if (err_set) err <= 1'b1;
      case (state)
        IDLE: if (s_valid) begin
          mask    <= h_mask;
          typ_ftm <= h_typ[1];
          rem     <= h_len;
          if (h_ok && h_typ == T_CLR) begin
            wb_clr <= h_mask;
            fb_clr <= h_mask;
          end
        end
        // a cfg payload without s_last is malformed and is not offered
        CFGW: if (s_valid && s_last) begin
          cfg_data  <= s_data[63:0];
          cfg_valid <= mask;
        end
        CFGH: cfg_valid <= cfg_valid & ~cfg_ready;
        CHK:  if (state_nxt == BURST) bcnt <= BW'(blen);
        BURST: if (s_valid) begin
          di   <= s_data;
          rem  <= rem - 16'd1;
          bcnt <= bcnt - BW'(1);
          if (typ_ftm) fb_we <= mask;
          else         wb_we <= mask;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/conv_feed_dispatcher.md
# conv_feed_dispatcher

Packet-driven feeder that sits between the DDR read stream and the array of conv units. It decodes header-prefixed packets and routes payload into each unit's config port and weight/feature-map buffers. It is the write side of the unit buffer protocol: it drives `di` and `wb_we`/`fb_we`, honours `wb_full`/`fb_full` at burst granularity, and delivers 64-bit layer config words over a valid/ready handshake.

## Interface
- `N_CONV_UNIT`, 8, number of conv units served (≤ 63)
- `DATA_WIDTH`, 64, stream and `di` width
- `UNIT_BURSTS_WEI`, 32, max words per weight burst (power of 2)
- `UNIT_BURSTS_FTM`, 1024, max words per ftm burst (power of 2)
- `clk`  in  1  clock
- `rstn`  in  1  reset; synchronous, active-low
- `s_valid`  in  1  input stream word valid
- `s_data`  in  DATA_WIDTH  input stream word
- `s_last`  in  1  last word of packet
- `s_ready`  out  1  word accepted when `s_valid & s_ready`
- `di`  out  DATA_WIDTH  registered write data, shared by all units
- `wb_we`  out  N_CONV_UNIT  weight buffer write strobe per unit
- `fb_we`  out  N_CONV_UNIT  ftm buffer write strobe per unit
- `wb_clr`, `fb_clr`  out  N_CONV_UNIT  one-cycle buffer clear pulses
- `wb_full`, `fb_full`  in  N_CONV_UNIT  unit cannot take one more burst
- `cfg_valid`  out  N_CONV_UNIT  config word offered
- `cfg_data`  out  64  config word, shared
- `cfg_ready`  in  N_CONV_UNIT  unit accepts config
- `err`  out  1  sticky protocol error; cleared only by reset

## Operation
- Header word (first word of each packet):
  - [63:62] type: 00 cfg, 01 wei, 10 ftm, 11 clear
  - [61:56] unit index
  - [55:40] n_words: payload length; ignored for cfg (1 word) and clear (0 words)
- States:
  - IDLE: `s_ready=1`. Accept header and decode.
    - Unit index ≥ N_CONV_UNIT: set `err`; go to DRAIN if not `s_last`, else stay in IDLE.
    - clear: pulse that unit's `wb_clr` and `fb_clr` next cycle; stay in IDLE.
    - cfg: go to CFGW.
    - wei/ftm with n_words=0: return to IDLE.
    - wei/ftm with n_words>0: go to GAP.
  - CFGW: `s_ready=1`. Accept one payload word, load `cfg_data`, then go to CFGH.
  - CFGH: hold `cfg_valid[u]=1` until `cfg_valid & cfg_ready`. Deassert the cycle after the transfer; return to IDLE.
  - GAP: one dead cycle so the previous registered write reaches the buffer. Then go to CHK.
  - CHK: `s_ready=0`. Wait until the target `*_full[u]==0`. Load burst length = min(remaining, UNIT_BURSTS_x). Go to BURST.
  - BURST: `s_ready=1`. Each accepted word produces `di` and `we[u]` one cycle later.
    - Burst count exhausted with remaining>0: go to GAP.
    - Remaining reaches 0: return to IDLE.
  - DRAIN: `s_ready=1`. Discard words until `s_last`; return to IDLE.
- Length checks:
  - `s_last` on the header of a wei/ftm packet with n_words>0, or on any non-final payload word: `err`, return to IDLE.
  - Final payload word without `s_last`: `err`, go to DRAIN.
  - A cfg header carrying `s_last`: `err`, return to IDLE.
- Counters: remaining is 16 bits; burst counter is $clog2(UNIT_BURSTS_FTM)+1 bits. No wrap occurs; loads are bounded by n_words.
- Reset mid-packet: return to IDLE; all strobes low next cycle. No partial burst resumes.

## Timing
- Reset values: `s_ready=0` during reset, 1 in IDLE after it. `di=0`, all `we`, `clr` and `cfg_valid` = 0, `cfg_data=0`, `err=0`.
- Data latency: accepted word at cycle t → `di`/`we` asserted at t+1, exactly one cycle per word. Stalls on `s_valid=0` give `we=0` that cycle.
- Full sampling: `*_full` is sampled only in CHK. Burst overhead is at least 2 cycles (GAP + CHK) between bursts.
- Simultaneous `cfg_ready` and `cfg_valid` rise: the transfer completes that cycle.
- `clr` pulse: cycle after the header handshake; exactly 1 cycle wide.

## Configuration
- `CONV_FEED_BCAST_EN`: header unit index 63 means broadcast.
  - wei/ftm: CHK waits until every unit's full flag is 0; `we` is driven to all units.
  - cfg: `cfg_valid` goes to all units; each bit drops on its own handshake; return to IDLE when all are done.
  - clear: pulses all units.
- Without the macro, index 63 is out-of-range → `err`.

## Test plan
- cfg packet for unit 2, payload 0xDEAD_BEEF_0000_0001, `cfg_ready[2]` delayed 5 cycles → `cfg_valid[2]` high exactly 6 cycles, `cfg_data` matches, other units untouched, `err=0`.
- wei packet unit 0, n_words=70, `wb_full=0` → 3 bursts (32, 32, 6); 70 `wb_we[0]` pulses with `di` in order; 2-cycle gap between bursts.
- ftm packet unit 5, n_words=10, `fb_full[5]=1` for 20 cycles → `s_ready=0` and no `fb_we` until full drops; 10 words then written.
- wei n_words=4 with `s_last` on 3rd payload word → `err=1`, 3 writes, FSM in IDLE; next valid packet processes normally.
- clear unit 7 → single-cycle `wb_clr[7]`, `fb_clr[7]`; index 9 with N_CONV_UNIT=8 → `err`, packet drained to `s_last`.
- Reset asserted mid-burst at word 10 of 32 → all `we` low next cycle, `err=0`; a new header is accepted after release.
